nabp_filter_sequencer: RTL and testbench
========================================

# nabp_filter_sequencer

Sequences the projection FIR filter (`NABPFilter`) across every projection angle. For each angle it streams the samples from the sinogram RAM into the filter, then appends zero samples to flush the pipeline. It writes each filtered sample, aligned by address, into the filtered-projection buffer that the back-projector reads, stalling the filter under downstream back-pressure.

## Interface
Parameters:
- `DATA_WIDTH`, 8: raw sample width (`kDataLength`).
- `FILTERED_WIDTH`, 16: filtered sample width (`kFilteredDataLength`).
- `PROJ_LEN`, 256: samples per projection line (P).
- `NUM_ANGLES`, 180: projection lines per frame (A).
- `FILTER_LATENCY`, 24: enabled-cycle latency of the filter (L). L ≥ taps−1, so L flush zeros clear the filter history.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `kick`  in  1  start pulse; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted kick until `done`.
- `done`  out  1  one-cycle pulse when the frame is complete.
- `src_rd_en`  out  1  sinogram read strobe.
- `src_angle`  out  clog2(A)  read angle.
- `src_addr`  out  clog2(P)  read sample index.
- `src_data`  in  DATA_WIDTH  read data, valid 1 cycle after `src_rd_en`; the source holds it while `src_rd_en` is low.
- `filter_enable`  out  1  drives filter `enable`.
- `filter_val_in`  out  DATA_WIDTH  filter input sample.
- `filter_val_out`  in  FILTERED_WIDTH  filter output sample.
- `dst_valid`  out  1  write request to the filtered buffer.
- `dst_ready`  in  1  buffer accepts the write when `dst_valid` && `dst_ready`.
- `dst_angle`  out  clog2(A)  write angle.
- `dst_addr`  out  clog2(P)  write sample index.
- `dst_data`  out  FILTERED_WIDTH  filtered sample.

## Operation
- **Advance condition:** `adv` = !(`dst_valid` && !`dst_ready`). When `adv` is low, all of the following freeze:
  - `src_rd_en` = 0 and `filter_enable` = 0;
  - counters, the stage-1 register and the dst registers hold.
- **Stage 0 (issue):** counter `cnt` runs 0..P+L−1 per angle.
  - For `cnt` < P: `src_rd_en` = 1, `src_addr` = `cnt`.
  - For P ≤ `cnt` < P+L: no read is issued.
- **Stage 1 (filter):** registered copy of the issue stage, giving stream index j.
  - `filter_enable` = 1 for each valid j.
  - `filter_val_in` = `src_data` if j < P, otherwise 0.
- **Output:** the filter output for stream index j−L is present on `filter_val_out` during enable-cycle j.
  - For j ≥ L, register `dst_valid` = 1, `dst_addr` = j−L, `dst_data` = `filter_val_out` and the current angle.
  - `dst_valid` clears after the handshake unless a new sample is loaded in the same cycle.
- **FSM:**
  - IDLE: on `kick`, go to FEED with angle = 0 and `cnt` = 0.
  - FEED: issues while `adv`. After the issue with `cnt` = P+L−1, go to NEXT.
  - NEXT: lasts one advancing cycle while stage 1 consumes the final j. If angle < A−1: angle++, `cnt` = 0, return to FEED. Otherwise go to FIN.
  - FIN: wait for `dst_valid` = 0, then pulse `done` and return to IDLE.
- **Boundaries:**
  - `kick` outside IDLE is ignored.
  - Angle wraps to 0 only via IDLE; no partial lines are ever written.
  - `reset_n` low mid-frame returns to IDLE immediately and drops any pending write; the filter's internal state is flushed by the next angle's zero tail.

## Timing
- **Reset values:** `busy`, `done`, `src_rd_en`, `filter_enable`, `dst_valid` = 0; all address, angle and data outputs = 0.
- **Per-angle cost:** P+L+1 advancing cycles.
- **Unstalled frame:** `kick` at cycle 0 → `done` at cycle A·(P+L+1)+2.
- **Example, P=4, L=2, A=1, `dst_ready` = 1:**
  - `src_rd_en` high in cycles 1–4.
  - `filter_enable` high in cycles 2–7.
  - `dst_valid` high in cycles 5–8 with addr 0..3.
  - `done` pulses in cycle 9.
- **Stalls:** each cycle with `dst_valid` && !`dst_ready` extends every later event by exactly one cycle.

## Structure
- The shared defines package holds:
  - the FSM state encoding (IDLE, FEED, NEXT, FIN);
  - `kProjectionLength`, `kNumAngles` and `kFilterLatency`;
  - the derived address and angle width macros, used as the parameter defaults.
- One sub-module, `nabp_filter_sequencer_out_stage`: the dst valid/ready holding register and the generation of `adv`.

## Test plan
- P=4, L=2, A=1, `dst_ready` = 1, filter modelled as a 2-cycle delay, `src_data` = addr+1 → writes addr 0..3 with data 1,2,3,4 in cycles 5–8; `done` in cycle 9.
- A=3 → each angle's writes carry `dst_angle` 0, 1, 2 in order; 12 writes total; `done` at cycle 23.
- `dst_ready` low for cycles 6–8 → `filter_enable` and `src_rd_en` low for those cycles, `dst_addr` = 1 held; `done` in cycle 12; no write lost or duplicated.
- `kick` reasserted in cycle 3 → ignored; exactly 4 writes and one `done`.
- `reset_n` low in cycle 4, `kick` in cycle 8 → all outputs 0 during reset; the new frame starts at angle 0, addr 0.
- Nonzero `src_data` followed by a second angle → each angle's `filter_val_in` reads 0 during the L flush samples after its P data samples.

Source files
------------

// File: rtl/nabp_filter_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// nabp_filter_sequencer_pkg
// Shared definitions for the projection filter sequencer:
//   - state_e     : sequencer FSM state encoding (IDLE, FEED, NEXT, FIN)
//   - kDataLength, kFilteredDataLength : raw / filtered sample widths
//   - kProjectionLength, kNumAngles, kFilterLatency : frame geometry
//   - width_of()  : clog2 that never returns 0, so single-entry ranges
//                   still get a 1-bit field
//   - kAddrWidth, kAngleWidth : derived address / angle widths
// ---------------------------------------------------------------------------
package nabp_filter_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_NEXT = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    localparam int kDataLength         = 8;
    localparam int kFilteredDataLength = 16;
    localparam int kProjectionLength   = 256;
    localparam int kNumAngles          = 180;
    localparam int kFilterLatency      = 24;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int kAddrWidth  = width_of(kProjectionLength);
    localparam int kAngleWidth = width_of(kNumAngles);

endpackage

// File: rtl/nabp_filter_sequencer_out_stage.sv
// ---------------------------------------------------------------------------
// nabp_filter_sequencer_out_stage
// Holding register for writes into the filtered-projection buffer, plus the
// pipeline advance signal derived from it.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   load_i              : capture a new filtered sample this cycle
//   angle_i/addr_i/data_i : sample tag and value to capture
//   dst_ready_i         : buffer accepts the held write
//   dst_valid_o, dst_angle_o, dst_addr_o, dst_data_o : held write request
//   adv_o               : whole sequencer pipeline may advance this cycle
//
// Handshake: a write transfers in a cycle where dst_valid_o && dst_ready_i.
// While dst_valid_o is high its angle/addr/data are stable. A held write that
// is not accepted stalls the whole pipeline (adv_o low), so load_i can only
// arrive while the register is empty or being drained that same cycle.
// ---------------------------------------------------------------------------
module nabp_filter_sequencer_out_stage
    import nabp_filter_sequencer_pkg::*;
#(
    parameter int FILTERED_WIDTH = kFilteredDataLength,
    parameter int ADDR_WIDTH     = kAddrWidth,
    parameter int ANGLE_WIDTH    = kAngleWidth
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_i,
    input  logic [ANGLE_WIDTH-1:0]    angle_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [FILTERED_WIDTH-1:0] data_i,
    input  logic                      dst_ready_i,
    output logic                      dst_valid_o,
    output logic [ANGLE_WIDTH-1:0]    dst_angle_o,
    output logic [ADDR_WIDTH-1:0]     dst_addr_o,
    output logic [FILTERED_WIDTH-1:0] dst_data_o,
    output logic                      adv_o
);

    logic                      valid_q;
    logic [ANGLE_WIDTH-1:0]    angle_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [FILTERED_WIDTH-1:0] data_q;

    assign adv_o = !(valid_q && !dst_ready_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            angle_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            angle_q <= angle_i;
            addr_q  <= addr_i;
            data_q  <= data_i;
        end else if (valid_q && dst_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign dst_valid_o = valid_q;
    assign dst_angle_o = angle_q;
    assign dst_addr_o  = addr_q;
    assign dst_data_o  = data_q;

endmodule

// File: rtl/nabp_filter_sequencer.sv
// ---------------------------------------------------------------------------
// nabp_filter_sequencer
// Streams every projection line from the sinogram RAM through the FIR filter,
// appends FILTER_LATENCY zero samples to flush it, and writes the aligned
// filtered samples into the filtered-projection buffer.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   kick                   : frame start (only honoured in IDLE)
//   busy, done             : frame in progress / one-cycle completion pulse
//   src_rd_en, src_angle, src_addr, src_data : sinogram read port
//                            (data returns one cycle after src_rd_en)
//   filter_enable, filter_val_in, filter_val_out : FIR filter connection
//   dst_valid, dst_ready, dst_angle, dst_addr, dst_data : buffer write port
//   state_dbg              : current FSM state
//
// Pipeline: stage 0 issues stream index cnt (reads for cnt < P, flush zeros
// after), stage 1 feeds index j to the filter, whose output for j-L appears
// during enable cycle j and is captured by the output stage. Everything
// freezes while a held write is refused.
// ---------------------------------------------------------------------------
module nabp_filter_sequencer
    import nabp_filter_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = kDataLength,
    parameter int FILTERED_WIDTH = kFilteredDataLength,
    parameter int PROJ_LEN       = kProjectionLength,
    parameter int NUM_ANGLES     = kNumAngles,
    parameter int FILTER_LATENCY = kFilterLatency,
    parameter int ADDR_WIDTH     = width_of(PROJ_LEN),
    parameter int ANGLE_WIDTH    = width_of(NUM_ANGLES)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      kick,
    output logic                      busy,
    output logic                      done,
    output logic                      src_rd_en,
    output logic [ANGLE_WIDTH-1:0]    src_angle,
    output logic [ADDR_WIDTH-1:0]     src_addr,
    input  logic [DATA_WIDTH-1:0]     src_data,
    output logic                      filter_enable,
    output logic [DATA_WIDTH-1:0]     filter_val_in,
    input  logic [FILTERED_WIDTH-1:0] filter_val_out,
    output logic                      dst_valid,
    input  logic                      dst_ready,
    output logic [ANGLE_WIDTH-1:0]    dst_angle,
    output logic [ADDR_WIDTH-1:0]     dst_addr,
    output logic [FILTERED_WIDTH-1:0] dst_data,
    output logic [1:0]                state_dbg
);

    // Stream index spans 0 .. P+L-1, so it needs its own width.
    localparam int CNT_WIDTH = width_of(PROJ_LEN + FILTER_LATENCY);

    localparam logic [CNT_WIDTH-1:0]   P_C          = CNT_WIDTH'(PROJ_LEN);
    localparam logic [CNT_WIDTH-1:0]   L_C          = CNT_WIDTH'(FILTER_LATENCY);
    localparam logic [CNT_WIDTH-1:0]   LAST_C       = CNT_WIDTH'(PROJ_LEN + FILTER_LATENCY - 1);
    localparam logic [ANGLE_WIDTH-1:0] ANGLE_LAST_C = ANGLE_WIDTH'(NUM_ANGLES - 1);

    state_e                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [ANGLE_WIDTH-1:0] angle_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   s1_valid_q;
    logic [CNT_WIDTH-1:0]   s1_j_q;

    logic                   adv;
    logic                   issue;
    logic                   load;
    logic [ADDR_WIDTH-1:0]  load_addr;

    // ---------------- stage 0: issue ----------------
    assign issue     = (state_q == ST_FEED) && adv;
    assign src_rd_en = issue && (cnt_q < P_C);
    assign src_addr  = ADDR_WIDTH'(cnt_q);
    assign src_angle = angle_q;

    // ---------------- stage 1: filter feed ----------------
    // Indices at or beyond P are the flush tail and feed zeros. The source
    // holds src_data across stalls, so a frozen stage 1 stays coherent.
    assign filter_enable = s1_valid_q && adv;
    assign filter_val_in = (s1_valid_q && (s1_j_q < P_C)) ? src_data : '0;

    // The first L enable cycles of a line only prime the filter.
    assign load      = filter_enable && (s1_j_q >= L_C);
    assign load_addr = ADDR_WIDTH'(s1_j_q - L_C);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_j_q     <= '0;
        end else if (adv) begin
            s1_valid_q <= (state_q == ST_FEED);
            s1_j_q     <= cnt_q;
        end
    end

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            angle_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (kick) begin
                        state_q <= ST_FEED;
                        cnt_q   <= '0;
                        angle_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FEED: begin
                    if (adv) begin
                        if (cnt_q == LAST_C) begin
                            state_q <= ST_NEXT;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                // Stage 1 consumes the line's final index here; the angle
                // only moves after that sample has been tagged.
                ST_NEXT: begin
                    if (adv) begin
                        if (angle_q == ANGLE_LAST_C) begin
                            state_q <= ST_FIN;
                        end else begin
                            angle_q <= angle_q + ANGLE_WIDTH'(1);
                            cnt_q   <= '0;
                            state_q <= ST_FEED;
                        end
                    end
                end
                // Nothing new can load here, so adv means the last write
                // is gone or leaving this cycle.
                ST_FIN: begin
                    if (adv) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

    nabp_filter_sequencer_out_stage #(
        .FILTERED_WIDTH (FILTERED_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .ANGLE_WIDTH    (ANGLE_WIDTH)
    ) u_out_stage (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (load),
        .angle_i     (angle_q),
        .addr_i      (load_addr),
        .data_i      (filter_val_out),
        .dst_ready_i (dst_ready),
        .dst_valid_o (dst_valid),
        .dst_angle_o (dst_angle),
        .dst_addr_o  (dst_addr),
        .dst_data_o  (dst_data),
        .adv_o       (adv)
    );

endmodule

// File: tb/tb_nabp_filter_sequencer.sv
module tb_nabp_filter_sequencer;

    localparam int P    = 4;
    localparam int L    = 2;
    localparam int A    = 3;
    localparam int PER  = P + L + 1;
    localparam int FRAME_DONE = A * PER + 2;
    localparam int W    = 20;   // {angle(2), addr(2), data(16)}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        kick;
    logic        busy, done;
    logic        src_rd_en;
    logic [1:0]  src_angle, src_addr;
    logic [7:0]  src_data;
    logic        filter_enable;
    logic [7:0]  filter_val_in;
    logic [15:0] filter_val_out;
    logic        dst_valid, dst_ready;
    logic [1:0]  dst_angle, dst_addr;
    logic [15:0] dst_data;
    logic [1:0]  state_dbg;

    nabp_filter_sequencer #(
        .DATA_WIDTH     (8),
        .FILTERED_WIDTH (16),
        .PROJ_LEN       (P),
        .NUM_ANGLES     (A),
        .FILTER_LATENCY (L)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .kick           (kick),
        .busy           (busy),
        .done           (done),
        .src_rd_en      (src_rd_en),
        .src_angle      (src_angle),
        .src_addr       (src_addr),
        .src_data       (src_data),
        .filter_enable  (filter_enable),
        .filter_val_in  (filter_val_in),
        .filter_val_out (filter_val_out),
        .dst_valid      (dst_valid),
        .dst_ready      (dst_ready),
        .dst_angle      (dst_angle),
        .dst_addr       (dst_addr),
        .dst_data       (dst_data),
        .state_dbg      (state_dbg)
    );

    // ---------------- environment models ----------------
    logic [7:0] mem [0:A-1][0:P-1];

    // Sinogram RAM: one-cycle read latency, holds data between reads.
    always @(posedge clk) begin
        if (src_rd_en) src_data <= mem[src_angle][src_addr];
    end

    // Filter: y[k] = x[k] + 2*x[k-1], output for index k appears L enabled
    // cycles after x[k] was presented.
    logic [15:0] fpipe [0:L-1];
    logic [7:0]  fprev;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < L; k++) fpipe[k] <= '0;
            fprev <= '0;
        end else if (filter_enable) begin
            fprev    <= filter_val_in;
            fpipe[0] <= 16'(filter_val_in) + 16'({fprev, 1'b0});
            for (int k = 1; k < L; k++) fpipe[k] <= fpipe[k-1];
        end
    end
    assign filter_val_out = fpipe[L-1];

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int rd_idx, en_idx, nwrites;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fresh random sinogram and the writes it must produce, in order.
    task automatic new_frame_data();
        int y;
        exp_q.delete();
        for (int a = 0; a < A; a++)
            for (int i = 0; i < P; i++)
                mem[a][i] = 8'($urandom_range(0, 255));
        for (int a = 0; a < A; a++)
            for (int i = 0; i < P; i++) begin
                y = int'(mem[a][i]);
                if (i > 0) y = y + 2 * int'(mem[a][i-1]);
                exp_q.push_back({2'(a), 2'(i), 16'(y)});
            end
        rd_idx  = 0;
        en_idx  = 0;
        nwrites = 0;
    endtask

    // Per-cycle stream checks: read order, filter input, written words.
    task automatic mon();
        int a, i;
        logic [7:0]   xe;
        logic [W-1:0] e;
        if (src_rd_en) begin
            chk("src_angle", 32'(src_angle), 32'(rd_idx / P));
            chk("src_addr",  32'(src_addr),  32'(rd_idx % P));
            rd_idx++;
        end
        if (filter_enable) begin
            a  = en_idx / (P + L);
            i  = en_idx % (P + L);
            xe = (i < P && a < A) ? mem[a][i] : 8'd0;
            chk("filter_val_in", 32'(filter_val_in), 32'(xe));
            en_idx++;
        end
        if (dst_valid && dst_ready) begin
            nwrites++;
            if (exp_q.size() == 0) begin
                chk("dst_extra_write", 32'(nwrites), 32'(A * P));
            end else begin
                e = exp_q.pop_front();
                chk("dst_word", 32'({dst_angle, dst_addr, dst_data}), 32'(e));
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy),          0);
        chk({tag, "_done"},      32'(done),          0);
        chk({tag, "_rd_en"},     32'(src_rd_en),     0);
        chk({tag, "_f_en"},      32'(filter_enable), 0);
        chk({tag, "_dst_valid"}, 32'(dst_valid),     0);
        chk({tag, "_src_addr"},  32'(src_addr),      0);
        chk({tag, "_src_angle"}, 32'(src_angle),     0);
        chk({tag, "_dst_addr"},  32'(dst_addr),      0);
        chk({tag, "_dst_angle"}, 32'(dst_angle),     0);
        chk({tag, "_dst_data"},  32'(dst_data),      0);
        chk({tag, "_f_in"},      32'(filter_val_in), 0);
        chk({tag, "_state"},     32'(state_dbg),     0);
    endtask

    // Unstalled schedule from the per-angle cost: angle k starts at 1+PER*k.
    task automatic check_schedule(input int rel);
        logic er, ee, ev;
        int   ea, eg, d;
        er = 0; ee = 0; ev = 0; ea = 0; eg = 0;
        for (int k = 0; k < A; k++) begin
            if (rel - 1 - PER * k >= 0 && rel - 1 - PER * k < P)     er = 1;
            if (rel - 2 - PER * k >= 0 && rel - 2 - PER * k < P + L) ee = 1;
            d = rel - 3 - L - PER * k;
            if (d >= 0 && d < P) begin ev = 1; ea = d; eg = k; end
        end
        chk("sched_rd_en",     32'(src_rd_en),     32'(er));
        chk("sched_f_en",      32'(filter_enable), 32'(ee));
        chk("sched_dst_valid", 32'(dst_valid),     32'(ev));
        if (ev) begin
            chk("sched_dst_addr",  32'(dst_addr),  32'(ea));
            chk("sched_dst_angle", 32'(dst_angle), 32'(eg));
        end
        chk("sched_done", 32'(done), 32'(rel == FRAME_DONE));
        chk("sched_busy", 32'(busy), 32'(rel >= 1 && rel < FRAME_DONE));
    endtask

    // mode 0: ready always high, 1: ready low in cycles 6..8, 2: random ready.
    // rekick >= 0 re-pulses kick at that cycle of the frame.
    task automatic run_frame(input int mode, input int rekick);
        int done_at, nstall, ndone;
        new_frame_data();
        done_at = -1; nstall = 0; ndone = 0;
        for (int rel = 0; rel < 400; rel++) begin
            @(posedge clk); #1;
            kick = (rel == 0) || (rel == rekick);
            case (mode)
                1:       dst_ready = !(rel >= 6 && rel <= 8);
                2:       dst_ready = ($urandom_range(0, 3) != 0);
                default: dst_ready = 1'b1;
            endcase
            @(negedge clk);
            mon();
            if (mode == 0) check_schedule(rel);
            if (mode == 1 && rel >= 6 && rel <= 8) begin
                chk("stall_f_en",      32'(filter_enable), 0);
                chk("stall_rd_en",     32'(src_rd_en),     0);
                chk("stall_dst_valid", 32'(dst_valid),     1);
                chk("stall_dst_addr",  32'(dst_addr),      1);
            end
            if (dst_valid && !dst_ready) nstall++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = rel;
            end
            if (done_at >= 0 && rel == done_at + 3) break;
        end
        chk("done_cycle",  32'(done_at),      32'(FRAME_DONE + nstall));
        chk("done_count",  32'(ndone),        1);
        chk("write_count", 32'(nwrites),      32'(A * P));
        chk("exp_q_left",  32'(exp_q.size()), 0);
        chk("idle_after",  32'(busy),         0);
        @(posedge clk); #1;
        kick      = 1'b0;
        dst_ready = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n   = 1'b0;
        kick      = 1'b0;
        dst_ready = 1'b1;
        new_frame_data();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_frame(0, -1);   // unstalled, exact schedule
        run_frame(1, -1);   // ready low in cycles 6..8
        run_frame(0, 3);    // kick during busy is ignored

        // Reset in cycle 4 of a frame, new kick in cycle 8.
        new_frame_data();
        for (int rel = 0; rel < 8; rel++) begin
            @(posedge clk); #1;
            kick = (rel == 0);
            if (rel == 4) reset_n = 1'b0;
            if (rel == 7) reset_n = 1'b1;
            @(negedge clk);
            if (rel < 4) mon();
            else if (rel < 7) check_idle_outputs("mid_reset");
            else chk("post_reset_state", 32'(state_dbg), 0);
        end
        run_frame(0, -1);   // starts at angle 0 / addr 0 after reset

        for (int n = 0; n < 3; n++) run_frame(2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
